// File: rtl/ax_arbiter_if.sv
// ax_arbiter_if: request/grant bundle between two AXI masters, the address
// decoder's selected slave and the ax_arbiter.
//   AxVALID_M0/M1 : address-valid requests from master 0 / master 1
//   AxREADY       : address-ready from the decoded slave
//   DONE          : end-of-transaction pulse (last read beat or write response)
//   gnt           : one-hot grant to the Ax/W muxes, 2'b00 = none
//   AxREADY_M0/M1 : address-ready routed back to the granted master
//   busy          : arbiter owns a transaction
// The slave modport is the arbiter side; the master modport is the
// requesters/slave side that drives the requests and observes the grant.
interface ax_arbiter_if;
  logic       AxVALID_M0;
  logic       AxVALID_M1;
  logic       AxREADY;
  logic       DONE;
  logic [1:0] gnt;
  logic       AxREADY_M0;
  logic       AxREADY_M1;
  logic       busy;

  modport slave (
    input  AxVALID_M0, AxVALID_M1, AxREADY, DONE,
    output gnt, AxREADY_M0, AxREADY_M1, busy
  );

  modport master (
    output AxVALID_M0, AxVALID_M1, AxREADY, DONE,
    input  gnt, AxREADY_M0, AxREADY_M1, busy
  );
endinterface

// File: rtl/ax_arbiter.sv
// ax_arbiter: two-master round-robin arbiter for one AXI address channel
// (one instance for reads, one for writes).
//   ACLK    : clock, all state on the rising edge
//   ARESETn : asynchronous active-low reset
//   bus     : ax_arbiter_if.slave (requests in; grant, readies, busy out)
// Parameters:
//   PRIORITY_INIT : master favoured first after reset (0 = M0, 1 = M1)
//   DONE_IS_LAST  : 1 = ownership ends on DONE, 0 = ends on the address handshake
// The grant is registered and held for the whole transaction so that the W and
// response paths stay routed to the owner until the transaction ends.
module ax_arbiter #(
  parameter bit PRIORITY_INIT = 1'b0,
  parameter bit DONE_IS_LAST  = 1'b1
) (
  input logic          ACLK,
  input logic          ARESETn,
  ax_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       rr_q, rr_d;
  logic       hs;

  // Address handshake of the current owner only; a valid from the other
  // master never completes a handshake.
  assign hs = bus.AxREADY &
              ((gnt_q[0] & bus.AxVALID_M0) | (gnt_q[1] & bus.AxVALID_M1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (bus.AxVALID_M0 | bus.AxVALID_M1) begin
          state_d = ADDR;
          if (bus.AxVALID_M0 & bus.AxVALID_M1) begin
            gnt_d = rr_q ? 2'b10 : 2'b01;
          end else begin
            gnt_d = {bus.AxVALID_M1, bus.AxVALID_M0};
          end
        end
      end
      ADDR: begin
        // DONE here is stray and ignored, even in the handshake cycle.
        if (hs) begin
          if (DONE_IS_LAST) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            rr_d    = gnt_q[0];
          end
        end
      end
      DATA: begin
        if (bus.DONE) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          // Favour the master that did not just own the channel.
          rr_d    = gnt_q[0];
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      rr_q    <= PRIORITY_INIT;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.AxREADY_M0 = bus.AxREADY & gnt_q[0] & (state_q == ADDR);
  assign bus.AxREADY_M1 = bus.AxREADY & gnt_q[1] & (state_q == ADDR);
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ax_arbiter.sv
// Bench for ax_arbiter: instance A uses DONE_IS_LAST=1, instance B uses
// DONE_IS_LAST=0; both share the same stimulus and reset.
module tb_ax_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic v0, v1, rdy, done;
  bit   armed = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ax_arbiter_if bus_a ();
  ax_arbiter_if bus_b ();

  assign bus_a.AxVALID_M0 = v0;
  assign bus_a.AxVALID_M1 = v1;
  assign bus_a.AxREADY    = rdy;
  assign bus_a.DONE       = done;
  assign bus_b.AxVALID_M0 = v0;
  assign bus_b.AxVALID_M1 = v1;
  assign bus_b.AxREADY    = rdy;
  assign bus_b.DONE       = done;

  ax_arbiter #(.PRIORITY_INIT(1'b0), .DONE_IS_LAST(1'b1)) dut_a (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus_a)
  );

  ax_arbiter #(.PRIORITY_INIT(1'b0), .DONE_IS_LAST(1'b0)) dut_b (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus_b)
  );

  // Transaction-level model: who owns the channel, whether its address has
  // been accepted yet, and who is favoured next. Index 0 = A, 1 = B.
  int m_own [2];
  bit m_ph  [2];
  int m_rr  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_own[i] <= -1;
        m_ph[i]  <= 1'b0;
        m_rr[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_own[i] < 0) begin
          if (v0 && v1)  m_own[i] <= m_rr[i];
          else if (v0)   m_own[i] <= 0;
          else if (v1)   m_own[i] <= 1;
          m_ph[i] <= 1'b0;
        end else if (!m_ph[i]) begin
          if (((m_own[i] == 0) ? v0 : v1) && rdy) begin
            if (i == 0) begin
              m_ph[i] <= 1'b1;
            end else begin
              m_own[i] <= -1;
              m_rr[i]  <= 1 - m_own[i];
            end
          end
        end else if (done) begin
          m_own[i] <= -1;
          m_rr[i]  <= 1 - m_own[i];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_gnt(input int own);
    if (own < 0) return 2'b00;
    return (own == 0) ? 2'b01 : 2'b10;
  endfunction

  logic [1:0] a_gnt [2];
  logic       a_busy [2];
  logic       a_r0 [2];
  logic       a_r1 [2];
  assign a_gnt[0] = bus_a.gnt;        assign a_gnt[1] = bus_b.gnt;
  assign a_busy[0] = bus_a.busy;      assign a_busy[1] = bus_b.busy;
  assign a_r0[0] = bus_a.AxREADY_M0;  assign a_r0[1] = bus_b.AxREADY_M0;
  assign a_r1[0] = bus_a.AxREADY_M1;  assign a_r1[1] = bus_b.AxREADY_M1;

  // Per-cycle compare against the model, one time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check(i == 0 ? "A.gnt" : "B.gnt", {30'd0, a_gnt[i]}, {30'd0, exp_gnt(m_own[i])});
        check(i == 0 ? "A.busy" : "B.busy", {31'd0, a_busy[i]}, {31'd0, m_own[i] >= 0});
        check(i == 0 ? "A.rdy_m0" : "B.rdy_m0", {31'd0, a_r0[i]},
              {31'd0, m_own[i] == 0 && !m_ph[i] && rdy});
        check(i == 0 ? "A.rdy_m1" : "B.rdy_m1", {31'd0, a_r1[i]},
              {31'd0, m_own[i] == 1 && !m_ph[i] && rdy});
        check(i == 0 ? "A.onehot" : "B.onehot", {31'd0, a_gnt[i] == 2'b11}, 32'd0);
      end
    end
  end

  task automatic step(input bit a0, input bit a1, input bit r, input bit d);
    @(negedge clk);
    v0 = a0; v1 = a1; rdy = r; done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, ".A.gnt"}, {30'd0, bus_a.gnt}, 32'd0);
    check({tag, ".A.busy"}, {31'd0, bus_a.busy}, 32'd0);
    check({tag, ".A.rdy"}, {30'd0, bus_a.AxREADY_M1, bus_a.AxREADY_M0}, 32'd0);
    check({tag, ".B.gnt"}, {30'd0, bus_b.gnt}, 32'd0);
  endtask

  logic [1:0] order [4];
  logic [1:0] seq_b [7];

  initial begin
    order = '{2'b01, 2'b10, 2'b01, 2'b10};
    seq_b = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; rdy = 1'b0; done = 1'b0;
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    check("idle.gnt", {30'd0, bus_a.gnt}, 32'd0);

    // Single M1 request, DONE four cycles after the request.
    step(0, 1, 1, 0);
    check("single.gnt", {30'd0, bus_a.gnt}, 32'd2);
    check("single.rdy_m1", {31'd0, bus_a.AxREADY_M1}, 32'd1);
    check("single.busy", {31'd0, bus_a.busy}, 32'd1);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("single.hold", {30'd0, bus_a.gnt}, 32'd2);
    step(0, 0, 0, 1);
    check("single.end", {30'd0, bus_a.gnt}, 32'd0);

    // Contention: alternating grants with one idle cycle between them.
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 1, 0);
      check("rr.order", {30'd0, bus_a.gnt}, {30'd0, order[k]});
      step(1, 1, 1, 0);
      step(1, 1, 0, 1);
      check("rr.gap", {30'd0, bus_a.gnt}, 32'd0);
    end

    // Slave stall on M0 with M1 waiting.
    step(1, 1, 0, 0);
    check("stall.gnt0", {30'd0, bus_a.gnt}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0);
      check("stall.gnt", {30'd0, bus_a.gnt}, 32'd1);
      check("stall.rdy_m0", {31'd0, bus_a.AxREADY_M0}, 32'd0);
    end
    step(1, 1, 1, 0);
    step(0, 1, 0, 0);
    check("stall.data", {30'd0, bus_a.gnt}, 32'd1);
    step(0, 1, 0, 1);
    check("stall.done", {30'd0, bus_a.gnt}, 32'd0);
    step(0, 1, 0, 0);
    check("stall.m1", {30'd0, bus_a.gnt}, 32'd2);
    step(0, 1, 1, 0);
    step(0, 0, 0, 1);

    // Stray DONE in IDLE and in ADDR.
    step(0, 0, 0, 1);
    check("stray.idle", {31'd0, bus_a.busy}, 32'd0);
    step(1, 1, 0, 1);
    check("stray.rr", {30'd0, bus_a.gnt}, 32'd1);
    step(1, 1, 0, 1);
    check("stray.addr", {30'd0, bus_a.gnt}, 32'd1);
    step(1, 1, 1, 0);
    check("stray.data", {30'd0, bus_a.gnt}, 32'd1);
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    check("stray.next", {30'd0, bus_a.gnt}, 32'd2);
    step(1, 1, 1, 0);
    check("mid.data", {30'd0, bus_a.gnt}, 32'd2);

    // Reset mid-DATA aborts at once; after release M0 is favoured again.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = 1'b1; v1 = 1'b1; rdy = 1'b0; done = 1'b0;
    @(posedge clk);
    #1;
    check("release.gnt", {30'd0, bus_a.gnt}, 32'd1);

    // DONE_IS_LAST=0 instance: alternation purely on address handshakes.
    @(negedge clk);
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = 1'b1; v1 = 1'b1; rdy = 1'b1;
    @(posedge clk);
    #1;
    check("b.seq", {30'd0, bus_b.gnt}, {30'd0, seq_b[0]});
    for (int k = 1; k < 7; k++) begin
      step(1, 1, 1, 0);
      check("b.seq", {30'd0, bus_b.gnt}, {30'd0, seq_b[k]});
    end

    // Pseudo-random traffic, checked only by the model.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
